// File: rtl/cpu_pkg.sv
// Shared CPU definitions: loader state encoding and instruction geometry,
// also used by the instruction memory.
package cpu_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int INSTR_W        = 32;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_RECV  = 3'd1,
    LD_WRITE = 3'd2,
    LD_CHK   = 3'd3,
    LD_DONE  = 3'd4
  } ld_state_e;

  // Running program checksum: a plain byte-wise XOR.
  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Little-endian byte-to-word assembler: the k-th accepted byte lands in bits [8k+7:8k].
module imem_word_assembler
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_valid,
  input  logic               i_ready,
  input  logic [7:0]         i_data,
  output logic [1:0]         o_byte_idx,
  output logic [INSTR_W-1:0] o_word,
  output logic               o_word_full
);

  logic [1:0]         r_idx;
  logic [INSTR_W-1:0] r_word;
  logic               w_take;

  assign w_take = i_valid & i_ready;

  // Byte lane write and index advance; a clear only rewinds the index since
  // every lane is overwritten before the next word is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= 2'd0;
      r_word <= {INSTR_W{1'b0}};
    end else if (i_clear) begin
      r_idx  <= 2'd0;
    end else if (w_take) begin
      r_word[{r_idx, 3'b000} +: 8] <= i_data;
      r_idx                        <= r_idx + 2'd1;
    end
  end

  assign o_byte_idx  = r_idx;
  assign o_word      = r_word;
  // Flags the beat that completes the word, so the FSM can move on this edge.
  assign o_word_full = w_take && (r_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader. Optional trailing checksum byte is
// enabled with the macro IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W:0]    word_count,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(2 ** ADDR_W);

  ld_state_e          r_state;
  ld_state_e          w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W:0]    r_count;
  logic               r_error;
  logic               w_clear;
  logic               w_asm_ready;
  logic               w_word_full;
  logic               w_count_ok;
  logic               w_accept_start;
  logic               w_last;
  logic               w_take;
  logic [1:0]         w_byte_idx;
  logic [INSTR_W-1:0] w_word;
  logic               w_chk_bad;

  assign w_count_ok     = (word_count != (ADDR_W + 1)'(0)) && (word_count <= DEPTH_L);
  assign w_accept_start = (r_state == LD_IDLE) && start && w_count_ok;
  assign w_last         = ({1'b0, r_addr} == (r_count - (ADDR_W + 1)'(1)));
  assign w_asm_ready    = (r_state == LD_RECV);
  assign w_take         = byte_valid & byte_ready;

  imem_word_assembler u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_valid     (byte_valid),
    .i_ready     (w_asm_ready),
    .i_data      (byte_data),
    .o_byte_idx  (w_byte_idx),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_xor;

  // Running XOR of program bytes only; the check byte itself is excluded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xor <= 8'd0;
    end else if (w_accept_start) begin
      r_xor <= 8'd0;
    end else if ((r_state == LD_RECV) && w_take) begin
      r_xor <= xor_fold(r_xor, byte_data);
    end
  end

  assign w_chk_bad  = (r_state == LD_CHK) && w_take && (byte_data != r_xor);
  assign byte_ready = (r_state == LD_RECV) || (r_state == LD_CHK);
`else
  assign w_chk_bad  = 1'b0;
  assign byte_ready = (r_state == LD_RECV);
`endif

  // Next-state decode.
  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    case (r_state)
      LD_IDLE: begin
        if (w_accept_start) begin
          w_next  = LD_RECV;
          w_clear = 1'b1;
        end else begin
          w_next  = LD_IDLE;
        end
      end
      LD_RECV: begin
        if (w_word_full) begin
          w_next = LD_WRITE;
        end else begin
          w_next = LD_RECV;
        end
      end
      LD_WRITE: begin
        w_clear = 1'b1;
        if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_next = LD_CHK;
`else
          w_next = LD_DONE;
`endif
        end else begin
          w_next = LD_RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      LD_CHK: begin
        if (w_take) begin
          w_next = LD_DONE;
        end else begin
          w_next = LD_CHK;
        end
      end
`endif
      LD_DONE: w_next = LD_IDLE;
      default: w_next = LD_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LD_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Word count latch and write address; the address never advances past the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= {ADDR_W{1'b0}};
      r_count <= {(ADDR_W + 1){1'b0}};
    end else if (w_accept_start) begin
      r_addr  <= {ADDR_W{1'b0}};
      r_count <= word_count;
    end else if ((r_state == LD_WRITE) && !w_last) begin
      r_addr  <= r_addr + ADDR_W'(1);
    end
  end

  // Error pulse: a rejected start, or a checksum miss that lands with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error <= 1'b0;
    end else begin
      r_error <= ((r_state == LD_IDLE) && start && !w_count_ok) || w_chk_bad;
    end
  end

  assign mem_we    = (r_state == LD_WRITE);
  assign mem_addr  = r_addr;
  assign mem_wdata = w_word;
  assign busy      = (r_state == LD_RECV) || (r_state == LD_WRITE) || (r_state == LD_CHK);
  assign cpu_hold  = busy;
  assign done      = (r_state == LD_DONE);
  assign error     = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random programs and byte gaps checked
// against a write-list model; honours IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   word_count = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready, mem_we, cpu_hold, busy, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: the ordered list of writes a load must produce.
  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t         exp_q[$];
  logic [31:0] prog[$];
  bit          exp_chk_err = 1'b0;

  int          cyc = 0, we_cnt = 0, done_cnt = 0, err_cnt = 0, last_we_cyc = 0;
  int          last_addr = 0;
  logic [31:0] last_wdata = 32'h0;

  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      check("busy_eq_hold", cpu_hold, busy);
      if (mem_we) begin
        we_cnt++;
        last_we_cyc = cyc;
        last_addr   = int'(mem_addr);
        last_wdata  = mem_wdata;
        check("ready_low_in_write", byte_ready, 1'b0);
        check("write_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wdata, e.data);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_busy_low", busy, 1'b0);
        check("done_hold_low", cpu_hold, 1'b0);
        check("done_error", error, exp_chk_err);
        if (!CHK_EN) check("done_latency", cyc - last_we_cyc, 1);
      end
      if (error) err_cnt++;
    end
  end

  // chk_mode: 0 none, 1 correct XOR byte, 2 the given byte.
  task automatic do_load(input int cnt, input int gap_pct, input int mid_start_at,
                         input int chk_mode, input logic [7:0] chk_byte);
    logic [7:0] bytes[$];
    logic [7:0] x;
    logic [7:0] b;
    int i, guard, g, d0, e0, w0;
    bit rdy;
    x = 8'h00;
    for (int w = 0; w < cnt; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'((prog[w] / (32'd1 << (8 * k))) % 32'd256);
        bytes.push_back(b);
        x = x ^ b;
      end
      exp_q.push_back('{w, prog[w]});
    end
    if (chk_mode == 1) bytes.push_back(x);
    if (chk_mode == 2) bytes.push_back(chk_byte);
    exp_chk_err = (chk_mode == 2) && (chk_byte != x);
    d0 = done_cnt; e0 = err_cnt; w0 = we_cnt;
    i = 0; guard = 0;
    @(negedge clk);
    while (i < bytes.size() && guard < 5000) begin
      start      = (guard == 0) || (guard == mid_start_at);
      word_count = (guard == mid_start_at) ? 7'd0 : 7'(cnt);
      if ($urandom_range(0, 99) < gap_pct) begin
        byte_valid = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_data  = bytes[i];
      end
      rdy = byte_ready;
      @(posedge clk);
      if (byte_valid && rdy) i++;
      guard++;
      @(negedge clk);
    end
    start = 1'b0; byte_valid = 1'b0;
    check("bytes_all_taken", i, bytes.size());
    g = 0;
    while (done_cnt == d0 && g < 100) begin
      @(negedge clk); #1;
      g++;
    end
    check("done_seen", done_cnt - d0, 1);
    check("write_count", we_cnt - w0, cnt);
    check("err_count", err_cnt - e0, exp_chk_err ? 1 : 0);
    check("queue_drained", exp_q.size(), 0);
    exp_chk_err = 1'b0;
  endtask

  task automatic illegal_start(input int cnt);
    int e0, w0;
    e0 = err_cnt; w0 = we_cnt;
    @(negedge clk);
    start = 1'b1; word_count = 7'(cnt);
    @(negedge clk);
    start = 1'b0;
    check("illegal_busy", busy, 1'b0);
    check("illegal_ready", byte_ready, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check("illegal_err_pulse", err_cnt - e0, 1);
    check("illegal_no_write", we_cnt - w0, 0);
    check("illegal_busy_after", busy, 1'b0);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_ready"}, byte_ready, 1'b0);
    check({nm, "_we"},    mem_we, 1'b0);
    check({nm, "_addr"},  mem_addr, 6'd0);
    check({nm, "_wdata"}, mem_wdata, 32'd0);
    check({nm, "_hold"},  cpu_hold, 1'b0);
    check({nm, "_busy"},  busy, 1'b0);
    check({nm, "_done"},  done, 1'b0);
    check({nm, "_error"}, error, 1'b0);
  endtask

  task automatic rand_prog(input int cnt);
    prog.delete();
    for (int w = 0; w < cnt; w++) prog.push_back($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    bit rdy;
    #22;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single word, literal program.
    prog.delete(); prog.push_back(32'h00002083);
    do_load(1, 0, -1, CHK_EN ? 1 : 0, 8'h00);
    check("t1_addr", last_addr, 0);
    check("t1_wdata", last_wdata, 32'h00002083);
    #1 check("t1_hold_released", cpu_hold, 1'b0);

    // Three words at consecutive addresses.
    prog.delete();
    prog.push_back(32'h00002083); prog.push_back(32'h00402103); prog.push_back(32'h00802183);
    do_load(3, 0, -1, CHK_EN ? 1 : 0, 8'h00);
    check("t2_last_addr", last_addr, 2);
    check("t2_last_wdata", last_wdata, 32'h00802183);

    // Illegal counts.
    illegal_start(0);
    illegal_start(DEPTH + 1);

    // Random gaps and a start pulse mid-load.
    rand_prog(8);
    do_load(8, 0, -1, CHK_EN ? 1 : 0, 8'h00);
    do_load(8, 40, 7, CHK_EN ? 1 : 0, 8'h00);
    for (int r = 0; r < 6; r++) begin
      int c;
      c = $urandom_range(1, 6);
      rand_prog(c);
      do_load(c, $urandom_range(0, 60), $urandom_range(2, 12), CHK_EN ? 1 : 0, 8'h00);
    end

    // Full depth: the last write is at DEPTH-1.
    rand_prog(DEPTH);
    do_load(DEPTH, 10, -1, CHK_EN ? 1 : 0, 8'h00);
    check("depth_last_addr", last_addr, DEPTH - 1);

    // Reset after two bytes of the second word.
    rand_prog(2);
    exp_q.push_back('{0, prog[0]});
    @(negedge clk);
    start = 1'b1; word_count = 7'd2;
    @(negedge clk);
    start = 1'b0;
    accepted = 0;
    for (int guard = 0; guard < 50 && accepted < 6; guard++) begin
      byte_valid = 1'b1;
      byte_data  = 8'((prog[accepted / 4] / (32'd1 << (8 * (accepted % 4)))) % 32'd256);
      rdy = byte_ready;
      @(posedge clk);
      if (rdy) accepted++;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    check("rst_bytes_taken", accepted, 6);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    check("midrst_word0_written", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rand_prog(2);
    do_load(2, 20, -1, CHK_EN ? 1 : 0, 8'h00);

`ifdef IMEM_LOADER_CHECKSUM_EN
    prog.delete(); prog.push_back(32'h00002083);
    do_load(1, 0, -1, 2, 8'hA3);
    do_load(1, 0, -1, 2, 8'h00);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
